// File: rtl/ec_req_ctrl.sv
// Request controller for a single-outstanding EC core: a 2-deep job FIFO feeds
// one issue at a time, then waits for the core result or a timeout.
module ec_req_ctrl #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       job_valid,
  output logic       job_ready,
  input  logic [5:0] job_Px,
  input  logic [5:0] job_Py,
  input  logic [5:0] job_Qx,
  input  logic [5:0] job_Qy,
  input  logic [5:0] job_prime,
  input  logic [5:0] job_a,
  output logic       in_valid,
  output logic [5:0] in_Px,
  output logic [5:0] in_Py,
  output logic [5:0] in_Qx,
  output logic [5:0] in_Qy,
  output logic [5:0] in_prime,
  output logic [5:0] in_a,
  input  logic       out_valid,
  input  logic [5:0] out_Rx,
  input  logic [5:0] out_Ry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_Rx,
  output logic [5:0] res_Ry,
  output logic       res_timeout,
  output logic       err_spurious,
  output logic [7:0] done_cnt
);

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 6;

  typedef struct packed {
    logic [DW-1:0] px;
    logic [DW-1:0] py;
    logic [DW-1:0] qx;
    logic [DW-1:0] qy;
    logic [DW-1:0] prime;
    logic [DW-1:0] a;
  } job_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  job_t          fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic          push, pop;
  job_t          job_in, head;

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  job_t          in_job_q, in_job_d;
  logic          in_valid_d;
  logic          res_valid_d, res_timeout_d, err_d;
  logic [DW-1:0] res_rx_d, res_ry_d;
  logic [7:0]    done_d;

  assign job_in    = '{px: job_Px, py: job_Py, qx: job_Qx, qy: job_Qy, prime: job_prime, a: job_a};
  assign head      = fifo_q[rd_ptr_q];
  assign job_ready = rst_n && (count_q != 2'd2);
  assign push      = job_valid && job_ready;
  assign pop       = (state_q == ISSUE);

  assign in_Px    = in_job_q.px;
  assign in_Py    = in_job_q.py;
  assign in_Qx    = in_job_q.qx;
  assign in_Qy    = in_job_q.qy;
  assign in_prime = in_job_q.prime;
  assign in_a     = in_job_q.a;

  // FIFO storage needs no reset; occupancy is tracked by pointers and count
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= job_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    in_valid_d    = 1'b0;
    in_job_d      = '0;
    res_valid_d   = res_valid;
    res_rx_d      = res_Rx;
    res_ry_d      = res_Ry;
    res_timeout_d = res_timeout;
    done_d        = done_cnt;
    err_d         = err_spurious | (out_valid && (state_q != WAIT));
    unique case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          state_d    = ISSUE;
          in_valid_d = 1'b1;
          in_job_d   = head;
          wait_cnt_d = '0;
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = wait_cnt_q + CW'(1);
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        // A core answer in the expiry cycle takes priority over the timeout
        if (out_valid) begin
          state_d       = RESP;
          res_valid_d   = 1'b1;
          res_rx_d      = out_Rx;
          res_ry_d      = out_Ry;
          res_timeout_d = 1'b0;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          state_d       = RESP;
          res_valid_d   = 1'b1;
          res_rx_d      = '0;
          res_ry_d      = '0;
          res_timeout_d = 1'b1;
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d       = IDLE;
          res_valid_d   = 1'b0;
          res_rx_d      = '0;
          res_ry_d      = '0;
          res_timeout_d = 1'b0;
          if (!res_timeout) done_d = done_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      in_valid     <= 1'b0;
      in_job_q     <= '0;
      res_valid    <= 1'b0;
      res_Rx       <= '0;
      res_Ry       <= '0;
      res_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      done_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      in_valid     <= in_valid_d;
      in_job_q     <= in_job_d;
      res_valid    <= res_valid_d;
      res_Rx       <= res_rx_d;
      res_Ry       <= res_ry_d;
      res_timeout  <= res_timeout_d;
      err_spurious <= err_d;
      done_cnt     <= done_d;
    end
  end

endmodule

// File: tb/tb_ec_req_ctrl.sv
// Randomized bench for ec_req_ctrl against a cycle-timestamp model of the
// job queue, issue timing, core response window and result handshake.
module tb_ec_req_ctrl;

  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       job_valid, job_ready;
  logic [5:0] job_Px, job_Py, job_Qx, job_Qy, job_prime, job_a;
  logic       in_valid;
  logic [5:0] in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a;
  logic       out_valid;
  logic [5:0] out_Rx, out_Ry;
  logic       res_valid, res_ready;
  logic [5:0] res_Rx, res_Ry;
  logic       res_timeout, err_spurious;
  logic [7:0] done_cnt;

  always #5 clk = ~clk;

  ec_req_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_Px(job_Px), .job_Py(job_Py), .job_Qx(job_Qx), .job_Qy(job_Qy),
    .job_prime(job_prime), .job_a(job_a),
    .in_valid(in_valid), .in_Px(in_Px), .in_Py(in_Py), .in_Qx(in_Qx), .in_Qy(in_Qy),
    .in_prime(in_prime), .in_a(in_a),
    .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry),
    .res_valid(res_valid), .res_ready(res_ready), .res_Rx(res_Rx), .res_Ry(res_Ry),
    .res_timeout(res_timeout), .err_spurious(err_spurious), .done_cnt(done_cnt)
  );

  typedef logic [35:0] job_t;

  int         n_chk = 0;
  int         n_pass = 0;
  longint     t = 0;

  // Reference model: queued jobs plus timestamps of expected events
  job_t       q[$];
  bit         idle_m;
  longint     issue_at, core_at, res_at;
  bit         res_on;
  logic [5:0] exp_rx, exp_ry;
  bit         exp_to;
  int         done_m;
  bit         spur_m;

  // Core behaviour: -1 random, 0 silent, >0 fixed answer delay after issue
  int         fix_delay = -1;
  logic [5:0] fix_rx = '0, fix_ry = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
  endtask

  function automatic job_t rnd_job();
    return 36'({$urandom(), $urandom()});
  endfunction

  function automatic void model_reset();
    q.delete();
    idle_m   = 1'b1;
    issue_at = -1;
    core_at  = -1;
    res_at   = -1;
    res_on   = 1'b0;
    exp_rx   = '0;
    exp_ry   = '0;
    exp_to   = 1'b0;
    done_m   = 0;
    spur_m   = 1'b0;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, advance the model
  task automatic cycle(input bit rst, input bit jv, input job_t jd, input bit rr, input bit ov_x);
    bit         push, ov, waiting;
    logic [5:0] orx, ory;
    int         r;
    @(negedge clk);
    check("in_valid", in_valid, t == issue_at);
    if (t == issue_at) check("in_data", {in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a}, q[0]);
    else               check("in_zero", {in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a}, 0);
    check("res_valid", res_valid, res_on);
    if (res_on) check("res_data", {res_timeout, res_Rx, res_Ry}, {exp_to, exp_rx, exp_ry});
    check("done_cnt", done_cnt, done_m);
    check("err_spurious", err_spurious, spur_m);

    ov  = (t == core_at) || ov_x;
    orx = 6'($urandom);
    ory = 6'($urandom);
    if (t == core_at && fix_delay > 0) begin
      orx = fix_rx;
      ory = fix_ry;
    end
    rst_n     = !rst;
    job_valid = jv;
    {job_Px, job_Py, job_Qx, job_Qy, job_prime, job_a} = jd;
    res_ready = rr;
    out_valid = ov;
    out_Rx    = orx;
    out_Ry    = ory;
    #1;
    check("job_ready", job_ready, !rst && (q.size() != 2));

    if (rst) begin
      model_reset();
    end else begin
      push    = jv && (q.size() != 2);
      waiting = (issue_at >= 0) && (t > issue_at) && (t < res_at) && !res_on;
      if (idle_m && q.size() > 0) begin
        issue_at = t + 1;
        idle_m   = 1'b0;
      end
      if (t == issue_at) begin
        void'(q.pop_front());
        res_at = t + TO;
        exp_to = 1'b1;
        exp_rx = '0;
        exp_ry = '0;
        if (fix_delay == 0)     core_at = -1;
        else if (fix_delay > 0) core_at = t + fix_delay;
        else begin
          r = $urandom_range(0, 3);
          if (r == 2)      core_at = -1;
          else if (r == 3) core_at = t + TO - 1;
          else             core_at = t + $urandom_range(1, 15);
        end
      end
      if (ov) begin
        if (waiting) begin
          res_at  = t + 1;
          exp_to  = 1'b0;
          exp_rx  = orx;
          exp_ry  = ory;
          core_at = -1;
        end else begin
          spur_m = 1'b1;
        end
      end
      if (res_on && rr) begin
        res_on = 1'b0;
        if (!exp_to) done_m = (done_m + 1) % 256;
        idle_m   = 1'b1;
        issue_at = -1;
        res_at   = -1;
      end else if (t + 1 == res_at) begin
        res_on = 1'b1;
      end
      if (push) q.push_back(jd);
    end
    t++;
  endtask

  initial begin
    bit saw_full;
    int accepted;
    model_reset();
    rst_n = 1'b0; job_valid = 1'b0; res_ready = 1'b0; out_valid = 1'b0;
    {job_Px, job_Py, job_Qx, job_Qy, job_prime, job_a} = '0;
    out_Rx = '0; out_Ry = '0;

    repeat (3) cycle(1, 0, '0, 0, 0);

    // Single known job answered after 10 cycles
    fix_delay = 10; fix_rx = 6'd5; fix_ry = 6'd9;
    cycle(0, 1, {6'd3, 6'd6, 6'd3, 6'd6, 6'd11, 6'd1}, 1, 0);
    repeat (20) cycle(0, 0, '0, 1, 0);
    check("single_done", done_cnt, 1);

    // Back-pressure: three jobs while results are held
    fix_delay = 5; saw_full = 1'b0; accepted = 0;
    for (int i = 0; i < 12 && accepted < 3; i++) begin
      cycle(0, 1, rnd_job(), 0, 0);
      if (job_ready) accepted++;
      else saw_full = 1'b1;
    end
    repeat (15) begin
      cycle(0, 0, '0, 0, 0);
      if (!job_ready) saw_full = 1'b1;
    end
    check("bp_full_seen", saw_full, 1);
    repeat (60) cycle(0, 0, '0, 1, 0);
    check("bp_done", done_cnt, 4);

    // Silent core, then an answer exactly in the expiry cycle
    fix_delay = 0;
    cycle(0, 1, rnd_job(), 1, 0);
    repeat (30) cycle(0, 0, '0, 1, 0);
    check("timeout_done", done_cnt, 4);
    fix_delay = TO - 1; fix_rx = 6'd42; fix_ry = 6'd17;
    cycle(0, 1, rnd_job(), 1, 0);
    repeat (30) cycle(0, 0, '0, 1, 0);
    check("expiry_done", done_cnt, 5);

    // Spurious strobe while idle, sticky until reset
    cycle(0, 0, '0, 1, 1);
    repeat (6) cycle(0, 0, '0, 1, 0);
    check("spur_sticky", err_spurious, 1);
    cycle(1, 0, '0, 0, 0);
    repeat (3) cycle(0, 0, '0, 1, 0);

    // Reset during WAIT, core answers three cycles after release
    fix_delay = 0;
    cycle(0, 1, rnd_job(), 0, 0);
    repeat (6) cycle(0, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 0);
    repeat (2) cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 1);
    repeat (4) cycle(0, 0, '0, 1, 0);
    check("rst_wait_err", err_spurious, 1);
    check("rst_wait_ready", job_ready, 1);
    cycle(1, 0, '0, 0, 0);

    // Random traffic
    fix_delay = -1;
    repeat (1500) cycle(0, $urandom_range(0, 2) == 0, rnd_job(), $urandom_range(0, 1) == 1, 0);

    // Fast core, saturating traffic, long enough to wrap done_cnt
    fix_delay = 1;
    repeat (1300) cycle(0, 1, rnd_job(), 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ec_req_ctrl.md
EC_REQ_CTRL -- requirements
Module: ec_req_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1000: max cycles waited for core out_valid after issue; legal range 2..1023.
REQ-002 Port list, one per line:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- job_valid  in  1  upstream job offered.
- job_ready  out  1  job FIFO not full.
- job_Px, job_Py, job_Qx, job_Qy, job_prime, job_a  in  6 each  job operands.
- in_valid  out  1  one-cycle issue pulse to EC core.
- in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a  out  6 each  operands to core.
- out_valid  in  1  core result strobe.
- out_Rx, out_Ry  in  6 each  core result.
- res_valid  out  1  result available downstream.
- res_ready  in  1  downstream accepts result.
- res_Rx, res_Ry  out  6 each  captured result.
- res_timeout  out  1  result is a timeout, not a core answer.
- err_spurious  out  1  sticky; out_valid seen while not in WAIT.
- done_cnt  out  8  count of non-timeout results delivered.

Function
REQ-003 Job FIFO: 2 entries x 36 bits; push on job_valid && job_ready; job_ready = (count != 2); push and pop in the same cycle at count 1 leaves count 1, head advances.
REQ-004 FSM states IDLE, ISSUE, WAIT, RESP; only one job is outstanding at the core at a time.
REQ-005 IDLE: FIFO non-empty -> ISSUE at next edge; otherwise stay.
REQ-006 ISSUE (exactly one cycle): in_valid=1, in_* = FIFO head; FIFO popped at the end of the cycle; wait counter cleared to 0; -> WAIT.
REQ-007 in_valid and all in_* SHALL be registered and SHALL be 0 in every cycle outside ISSUE.
REQ-008 Job accepted at edge N into an empty FIFO with FSM in IDLE: in_valid high in the cycle following edge N+1.
REQ-009 WAIT: counter increments each cycle. On out_valid=1: capture out_Rx/out_Ry, res_timeout=0, -> RESP.
REQ-010 WAIT: counter reaches TIMEOUT-1 with out_valid=0: res_Rx=res_Ry=0, res_timeout=1, -> RESP.
REQ-011 out_valid in the same cycle as timeout expiry: the result wins; res_timeout=0.
REQ-012 RESP: res_valid=1 and res_* stable until res_ready=1. On handshake: -> IDLE; done_cnt += 1 if res_timeout=0; done_cnt wraps 255 -> 0.
REQ-013 out_valid=1 in IDLE, ISSUE or RESP: sets err_spurious (sticky until reset); data ignored; state unaffected.
REQ-014 Job pushes continue in any state while the FIFO is not full.
REQ-015 All outputs except job_ready are registered; job_ready is decoded from the registered FIFO count.

Reset
REQ-016 rst_n=0 sampled at an edge: FSM -> IDLE, FIFO emptied, counters and all outputs 0, including err_spurious and done_cnt.
REQ-017 Reset mid-operation (ISSUE, WAIT or RESP): the job in flight is discarded with no res_valid. A core result arriving after reset release sets err_spurious.
REQ-018 job_ready is 0 while rst_n=0 and 1 in the first cycle after release.

Verification
REQ-019 Single job: Px=3, Py=6, Qx=3, Qy=6, prime=11, a=1; core model answers Rx=5, Ry=9 after 10 cycles. Expect one in_valid pulse with exact operands and all in_* = 0 otherwise; res_valid with 5/9, res_timeout=0; done_cnt=1.
REQ-020 Back-pressure: push 3 jobs back-to-back with res_ready=0. Expect job_ready low after 2 accepts while job 1 waits. Jobs are issued strictly in order, with no second in_valid before the first RESP handshake.
REQ-021 Timeout with TIMEOUT=20 and the core silent. Expect res_valid 20 cycles after issue with Rx=Ry=0, res_timeout=1; done_cnt unchanged.
REQ-022 Boundary: out_valid asserted in the exact expiry cycle. Expect the core data delivered with res_timeout=0.
REQ-023 Spurious: out_valid pulse while IDLE. Expect err_spurious=1 held and no res_valid; cleared only by rst_n=0.
REQ-024 Reset in WAIT, then core out_valid 3 cycles later. Expect no res_valid, err_spurious=1, FIFO empty, job_ready=1.
